// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code output monitor.
package gray_pkg;

    localparam int GRAY_W_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        RESYNC = 2'd2
    } mon_state_t;

    // Width-generic Gray-to-binary conversion. Narrower codes are passed
    // zero-extended; zero upper bits leave the lower result bits unchanged,
    // so one routine covers every width up to 32 bits.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Purely combinational Gray-to-binary converter.
module gray2bin_comb #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Each binary bit is the XOR of the Gray bits from the MSB down to
    // itself. This form avoids a bit-to-bit dependency chain on one vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_monitor.sv
// Checks that an upstream Gray counter only holds or advances by one,
// counts wrap-arounds and flags illegal steps.
module gray_monitor
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W_DEFAULT,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [WIDTH-1:0] GrayIn,
    input  logic             OvfIn,
    output logic [WIDTH-1:0] Binary,
    output logic             Locked,
    output logic             StepErr,
    output logic             ErrSticky,
    output logic             OvfSeen,
    output logic [CNT_W-1:0] Wraps,
    output logic [CNT_W-1:0] ErrCnt
);

    localparam logic [WIDTH-1:0] CODE_MAX = '1;
    localparam logic [WIDTH-1:0] CODE_ONE = WIDTH'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mon_state_t       state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             step_err_q, step_err_d;
    logic             err_sticky_q, err_sticky_d;
    logic             ovf_seen_q, ovf_seen_d;
    logic [CNT_W-1:0] wraps_q, wraps_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] cur;

    gray2bin_comb #(.WIDTH(WIDTH)) u_conv (
        .gray_i (GrayIn),
        .bin_o  (cur)
    );

    // Next-state: everything holds unless En samples; the error pulse
    // always defaults low so it lasts exactly one cycle.
    always_comb begin
        state_d      = state_q;
        ref_d        = ref_q;
        bin_d        = bin_q;
        step_err_d   = 1'b0;
        err_sticky_d = err_sticky_q;
        ovf_seen_d   = ovf_seen_q;
        wraps_d      = wraps_q;
        err_cnt_d    = err_cnt_q;
        if (En) begin
            bin_d = cur;
            if (OvfIn) ovf_seen_d = 1'b1;
            case (state_q)
                IDLE, RESYNC: begin
                    // (Re)acquire the reference without checking.
                    ref_d   = cur;
                    state_d = TRACK;
                end
                TRACK: begin
                    if (cur == ref_q) begin
                        // hold
                    end else if (ref_q != CODE_MAX && cur == ref_q + CODE_ONE) begin
                        ref_d = cur;
                    end else if (ref_q == CODE_MAX && cur == '0) begin
                        ref_d = '0;
                        if (wraps_q != CNT_MAX) wraps_d = wraps_q + CNT_ONE;
                    end else begin
                        step_err_d   = 1'b1;
                        err_sticky_d = 1'b1;
                        if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_ONE;
                        state_d      = RESYNC;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers, cleared asynchronously on Reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            ref_q        <= '0;
            bin_q        <= '0;
            step_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            ovf_seen_q   <= 1'b0;
            wraps_q      <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ref_q        <= ref_d;
            bin_q        <= bin_d;
            step_err_q   <= step_err_d;
            err_sticky_q <= err_sticky_d;
            ovf_seen_q   <= ovf_seen_d;
            wraps_q      <= wraps_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign Binary    = bin_q;
    assign Locked    = (state_q == TRACK);
    assign StepErr   = step_err_q;
    assign ErrSticky = err_sticky_q;
    assign OvfSeen   = ovf_seen_q;
    assign Wraps     = wraps_q;
    assign ErrCnt    = err_cnt_q;

endmodule

// File: tb/tb_gray_monitor.sv
// Directed bench for gray_monitor: default build plus a CNT_W=2 build
// driven with the same stimulus for the saturation scenario.
module tb_gray_monitor;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       En = 1'b0;
    logic [2:0] GrayIn = 3'b000;
    logic       OvfIn = 1'b0;

    logic [2:0] Binary;
    logic       Locked, StepErr, ErrSticky, OvfSeen;
    logic [7:0] Wraps, ErrCnt;

    logic [2:0] Binary2;
    logic       Locked2, StepErr2, ErrSticky2, OvfSeen2;
    logic [1:0] Wraps2, ErrCnt2;

    int checks = 0;
    int failures = 0;

    // Gray code for binary index 0..7.
    logic [2:0] gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                             3'b110, 3'b111, 3'b101, 3'b100};

    always #5 Clk = ~Clk;

    gray_monitor #(.WIDTH(3), .CNT_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .En(En), .GrayIn(GrayIn), .OvfIn(OvfIn),
        .Binary(Binary), .Locked(Locked), .StepErr(StepErr),
        .ErrSticky(ErrSticky), .OvfSeen(OvfSeen), .Wraps(Wraps), .ErrCnt(ErrCnt)
    );

    gray_monitor #(.WIDTH(3), .CNT_W(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .En(En), .GrayIn(GrayIn), .OvfIn(OvfIn),
        .Binary(Binary2), .Locked(Locked2), .StepErr(StepErr2),
        .ErrSticky(ErrSticky2), .OvfSeen(OvfSeen2), .Wraps(Wraps2), .ErrCnt(ErrCnt2)
    );

    // One clock with the given inputs; outputs are settled 1 time unit later.
    task automatic step(input logic [2:0] g, input logic en);
        GrayIn = g;
        En     = en;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (Binary !== 3'd0) begin failures++; $display("FAIL reset_binary got=%0d exp=0", Binary); end
        checks++; if ({Locked, StepErr, ErrSticky, OvfSeen} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {Locked, StepErr, ErrSticky, OvfSeen}); end
        checks++; if (Wraps !== 8'd0 || ErrCnt !== 8'd0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", Wraps, ErrCnt); end
        Reset = 1'b0;
    endtask

    task automatic test_legal_seq;
        for (int i = 0; i <= 8; i++) begin
            step(gseq[i % 8], 1'b1);
            checks++; if (Binary !== 3'(i % 8)) begin failures++; $display("FAIL legal_binary[%0d] got=%0d exp=%0d", i, Binary, i % 8); end
            checks++; if (Locked !== 1'b1 || StepErr !== 1'b0) begin failures++; $display("FAIL legal_lock_err[%0d] got=%b%b exp=10", i, Locked, StepErr); end
        end
        checks++; if (Wraps !== 8'd1) begin failures++; $display("FAIL legal_wraps got=%0d exp=1", Wraps); end
    endtask

    task automatic test_illegal;
        step(3'b001, 1'b1);
        step(3'b011, 1'b1);               // reference = 2
        step(3'b101, 1'b1);               // 6: illegal
        checks++; if (StepErr !== 1'b1 || ErrSticky !== 1'b1) begin failures++; $display("FAIL illegal_flags got=%b%b exp=11", StepErr, ErrSticky); end
        checks++; if (ErrCnt !== 8'd1 || Locked !== 1'b0) begin failures++; $display("FAIL illegal_cnt_lock got=%0d/%b exp=1/0", ErrCnt, Locked); end
        checks++; if (Binary !== 3'd6) begin failures++; $display("FAIL illegal_binary got=%0d exp=6", Binary); end
        step(3'b100, 1'b1);               // resync to 7
        checks++; if (StepErr !== 1'b0 || Locked !== 1'b1 || ErrSticky !== 1'b1) begin failures++; $display("FAIL resync got=%b%b%b exp=011", StepErr, Locked, ErrSticky); end
        checks++; if (ErrCnt !== 8'd1 || Binary !== 3'd7) begin failures++; $display("FAIL resync_cnt got=%0d/%0d exp=1/7", ErrCnt, Binary); end
        step(3'b000, 1'b1);               // 7 -> 0 wrap
        checks++; if (Wraps !== 8'd2 || StepErr !== 1'b0) begin failures++; $display("FAIL resync_wrap got=%0d/%b exp=2/0", Wraps, StepErr); end
    endtask

    task automatic test_hold;
        step(3'b001, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(3'b011, 1'b1);
            checks++; if (Binary !== 3'd2 || StepErr !== 1'b0 || Locked !== 1'b1) begin failures++; $display("FAIL hold[%0d] got=%0d/%b/%b exp=2/0/1", i, Binary, StepErr, Locked); end
        end
        step(3'b010, 1'b1);
        checks++; if (Binary !== 3'd3 || StepErr !== 1'b0) begin failures++; $display("FAIL hold_adv got=%0d/%b exp=3/0", Binary, StepErr); end
        checks++; if (Wraps !== 8'd2 || ErrCnt !== 8'd1) begin failures++; $display("FAIL hold_counts got=%0d/%0d exp=2/1", Wraps, ErrCnt); end
    endtask

    task automatic test_enable;
        logic [2:0] junk [3] = '{3'b101, 3'b000, 3'b111};
        for (int i = 0; i < 3; i++) begin
            step(junk[i], 1'b0);
            checks++; if (Binary !== 3'd3 || Locked !== 1'b1 || StepErr !== 1'b0) begin failures++; $display("FAIL en_freeze[%0d] got=%0d/%b/%b exp=3/1/0", i, Binary, Locked, StepErr); end
            checks++; if (Wraps !== 8'd2 || ErrCnt !== 8'd1) begin failures++; $display("FAIL en_freeze_cnt[%0d] got=%0d/%0d exp=2/1", i, Wraps, ErrCnt); end
        end
        step(3'b110, 1'b1);               // 4 follows held reference 3
        checks++; if (Binary !== 3'd4 || StepErr !== 1'b0) begin failures++; $display("FAIL en_resume got=%0d/%b exp=4/0", Binary, StepErr); end
    endtask

    task automatic test_back_to_back;
        step(3'b000, 1'b1);               // 4 -> 0 illegal
        checks++; if (StepErr !== 1'b1 || ErrCnt !== 8'd2) begin failures++; $display("FAIL b2b_first got=%b/%0d exp=1/2", StepErr, ErrCnt); end
        step(3'b000, 1'b1);               // resync sample, not checked
        checks++; if (StepErr !== 1'b0 || Locked !== 1'b1) begin failures++; $display("FAIL b2b_resync got=%b/%b exp=0/1", StepErr, Locked); end
        step(3'b011, 1'b1);               // 0 -> 2 illegal
        checks++; if (StepErr !== 1'b1 || ErrCnt !== 8'd3 || Locked !== 1'b0) begin failures++; $display("FAIL b2b_second got=%b/%0d/%b exp=1/3/0", StepErr, ErrCnt, Locked); end
        step(3'b111, 1'b0);               // frozen in RESYNC, pulse drops
        checks++; if (StepErr !== 1'b0 || Locked !== 1'b0 || ErrCnt !== 8'd3 || Binary !== 3'd2) begin failures++; $display("FAIL b2b_freeze got=%b/%b/%0d/%0d exp=0/0/3/2", StepErr, Locked, ErrCnt, Binary); end
        step(3'b010, 1'b1);
        step(3'b110, 1'b1);
        checks++; if (StepErr !== 1'b0 || Locked !== 1'b1 || Binary !== 3'd4 || ErrCnt !== 8'd3) begin failures++; $display("FAIL b2b_recover got=%b/%b/%0d/%0d exp=0/1/4/3", StepErr, Locked, Binary, ErrCnt); end
    endtask

    task automatic test_ovf_reset;
        OvfIn = 1'b1;
        step(3'b111, 1'b1);
        OvfIn = 1'b0;
        checks++; if (OvfSeen !== 1'b1 || Binary !== 3'd5) begin failures++; $display("FAIL ovf_seen got=%b/%0d exp=1/5", OvfSeen, Binary); end
        #2 Reset = 1'b1;                  // mid-cycle
        #1;
        checks++; if ({Locked, StepErr, ErrSticky, OvfSeen} !== 4'b0 || Binary !== 3'd0) begin failures++; $display("FAIL async_reset_flags got=%b/%0d exp=0000/0", {Locked, StepErr, ErrSticky, OvfSeen}, Binary); end
        checks++; if (Wraps !== 8'd0 || ErrCnt !== 8'd0) begin failures++; $display("FAIL async_reset_cnt got=%0d/%0d exp=0/0", Wraps, ErrCnt); end
        @(negedge Clk);
        Reset = 1'b0;
        step(3'b011, 1'b1);               // arbitrary entry value, no check from IDLE
        checks++; if (Locked !== 1'b1 || StepErr !== 1'b0 || ErrSticky !== 1'b0 || Binary !== 3'd2) begin failures++; $display("FAIL post_reset got=%b/%b/%b/%0d exp=1/0/0/2", Locked, StepErr, ErrSticky, Binary); end
    endtask

    task automatic test_saturation;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        step(3'b000, 1'b1);
        for (int c = 0; c < 7; c++) begin
            for (int i = 1; i <= 8; i++) step(gseq[i % 8], 1'b1);
        end
        checks++; if (Wraps2 !== 2'd3) begin failures++; $display("FAIL sat_wraps_cnt2 got=%0d exp=3", Wraps2); end
        checks++; if (Wraps !== 8'd7) begin failures++; $display("FAIL sat_wraps_cnt8 got=%0d exp=7", Wraps); end
        checks++; if (StepErr2 !== 1'b0 || ErrCnt2 !== 2'd0 || Binary2 !== 3'd0) begin failures++; $display("FAIL sat_clean got=%b/%0d/%0d exp=0/0/0", StepErr2, ErrCnt2, Binary2); end
    endtask

    initial begin
        test_reset;
        test_legal_seq;
        test_illegal;
        test_hold;
        test_enable;
        test_back_to_back;
        test_ovf_reset;
        test_saturation;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
